// File: rtl/mul_div_if.sv
// Handshake and result bundle between the control path and mul_div_unit.
// Ports (as seen by the unit):
//   start, op[1:0], opa, opb : request and operands from the control FSM and register file
//   busy, done, hi, lo, dz   : status and result back to the control path
interface mul_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (
    output start, op, opa, opb,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, hi, lo, dz
  );
endinterface

// File: rtl/mul_div_unit.sv
// Sequential multiply/divide unit, one operand bit per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mul_div_if slave (start/op/opa/opb in; busy/done/hi/lo/dz out)
// op: 00 MULU, 01 MUL, 10 DIVU, 11 DIV. MUL -> hi:lo = product;
// DIV -> lo = quotient, hi = remainder.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / restoring-subtract step per cycle
// FIX   | sign correction, result write
// DONE  | result valid for one cycle, may accept next start
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               neg_a;
  logic               neg_b;
  // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0]   mcand;
  // MUL: {partial product, remaining multiplier}; DIV: lower half holds dividend -> quotient
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // 0x8000 maps to itself, which reads correctly as unsigned 32768
  assign abs_a = (bus.op[0] && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
  assign abs_b = (bus.op[0] && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

  // div_shift <= 2*divisor-1, so the MSB of the difference is exactly the borrow
  assign div_shift = {rem, prod[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};

  assign res_neg  = neg_a ^ neg_b;
  assign prod_fix = res_neg ? -prod : prod;
  assign quo_fix  = res_neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign rem_fix  = neg_a ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      rem    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          if (bus.start) begin
            op_q  <= bus.op;
            neg_a <= bus.op[0] & bus.opa[WIDTH-1];
            neg_b <= bus.op[0] & bus.opb[WIDTH-1];
            cnt   <= '0;
            if (bus.op[1] && bus.opb == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              hi_q   <= bus.opa;
              lo_q   <= '1;
              dz_q   <= 1'b1;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
              mcand  <= bus.op[1] ? abs_b : abs_a;
              prod   <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
              rem    <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            rem                <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            prod[WIDTH-1:0]    <= {prod[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          dz_q   <= 1'b0;
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_if #(.WIDTH(16)) bus();

  mul_div_unit #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: compares every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 with no pending result (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("hi", bus.hi, mon_e.hi);
          chk("lo", bus.lo, mon_e.lo);
          chk("dz", bus.dz, mon_e.dz);
          chk("busy_at_done", bus.busy, 0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        mon_e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_done: no done at cycle %0d, expected at %0d", cyc, mon_e.cyc);
      end
    end
  end

  // called #1 after a posedge; start is accepted on the next posedge
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ehi, input logic [15:0] elo, input logic edz);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    e.hi  = ehi;
    e.lo  = elo;
    e.dz  = edz;
    e.cyc = cyc + 1 + (edz ? 0 : 17);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, edz ? 0 : 1);
    chk("done_after_accept", bus.done, edz);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_done: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   t;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = '0;
    bus.opb   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_dz", bus.dz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0); wait_done();
    issue(2'b01, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0); wait_done();
    issue(2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0); wait_done();
    issue(2'b10, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0); wait_done();
    issue(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0); wait_done();
    issue(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0); wait_done();

    // divide by zero: straight to DONE, busy stays low
    issue(2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    chk("dz_done_drop", bus.done, 0);
    chk("dz_busy_low", bus.busy, 0);
    wait_done();
    issue(2'b00, 16'd2, 16'd3, 16'h0000, 16'h0006, 1'b0); wait_done();

    // start pulsed mid-CALC must be ignored
    issue(2'b10, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 16'hFFFF;
    bus.opb   = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_ignored_start", bus.busy, 1);
    wait_done();

    // start held high through the done cycle: second op accepted on that edge
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 16'hFFFF;
    bus.opb   = 16'hFFFF;
    t = cyc + 1;
    e.hi = 16'hFFFE; e.lo = 16'h0001; e.dz = 1'b0; e.cyc = t + 17;
    sb.push_back(e);
    e.hi = 16'hFFFF; e.lo = 16'hFFEB; e.dz = 1'b0; e.cyc = t + 35;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.op  = 2'b01;
    bus.opa = 16'hFFFD;
    bus.opb = 16'h0007;
    repeat (18) @(posedge clk);
    #1;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done", bus.done, 0);
    bus.start = 1'b0;
    wait_done();

    // reset in the middle of CALC aborts without writing a result
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = 16'd100;
    bus.opb   = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0); wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Sequential 16-bit multiply/divide unit for the multicycle MIPS datapath. It sits directly downstream of the register file: it takes the two read-port operands (rd1, rd2) when the control FSM pulses `start`, and iterates one bit per cycle. It holds a 32-bit result in HI/LO registers, which the control path later writes back through the register-file write port.

## Interface
- WIDTH, 16, operand width; HI and LO are each WIDTH bits. Only 16 is required and verified.
- clk  input  1  clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the unit is in IDLE or DONE.
- op  input  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed); sampled with start.
- opa  input  16  multiplicand / dividend (from rd1); sampled with start.
- opb  input  16  multiplier / divisor (from rd2); sampled with start.
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse; high exactly while in DONE.
- hi  output  16  MUL: upper product half; DIV: remainder.
- lo  output  16  MUL: lower product half; DIV: quotient.
- dz  output  1  divide-by-zero flag for the last result.

## Operation
- States:
  - IDLE -> CALC on accepted start.
  - CALC runs 16 iterations, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE, or -> CALC if start is high again (back-to-back is allowed).
- Accept: on the posedge where start=1 and state is IDLE or DONE, latch op, |opa|, |opb| (absolute values only for signed ops) and the result sign bits. Clear the iteration counter.
- start while busy is ignored; latched operands are not disturbed.
- Multiply: shift-add over a 32-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring divide, 17-bit partial remainder, one quotient bit per cycle, MSB first.
- FIX applies sign correction, then writes hi/lo/dz:
  - MUL: the product is negated if the operand signs differ.
  - DIV: quotient truncates toward zero. The quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Overflow: DIV 0x8000 / 0xFFFF gives lo=0x8000 (wrap), hi=0x0000, dz=0.
- Divide by zero (op[1]=1, opb=0): at accept, skip CALC/FIX and go straight to DONE. Set hi=opa, lo=0xFFFF, dz=1.
- dz is cleared by every non-zero-divisor result.
- hi, lo and dz change only on the FIX->DONE edge (or the divide-by-zero accept edge). They hold their value otherwise, including while a new operation is in progress.
- MUL results are unaffected by the value of dz.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, hi=0x0000, lo=0x0000, dz=0, counter=0. Reset asserted mid-operation aborts it; no result is written.
- Start accepted at edge T:
  - busy=1 from after T until after T+17.
  - CALC iterations on edges T+1..T+16.
  - FIX on edge T+17 writes hi/lo.
  - done=1 between T+17 and T+18; busy=0 at that point.
- Result latency: 17 cycles from the accepting edge to valid hi/lo.
- Divide by zero accepted at T: hi/lo/dz valid and done=1 between T and T+1; busy stays 0.
- A start asserted while done=1 is accepted on that edge. done drops and busy rises on the same edge.
- Outputs are registered (no combinational path from inputs to outputs).
- The register file reads on negedge, so opa/opb are stable at posedge.

## Test plan
- **MULU:** op=00, opa=0xFFFF, opb=0xFFFF -> done exactly 17 cycles after accept; hi=0xFFFE, lo=0x0001, dz=0.
- **Signed MUL:** op=01, opa=0xFFFD (-3), opb=0x0007 -> hi=0xFFFF, lo=0xFFEB (-21). Also 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
- **Divides:**
  - op=10, opa=100, opb=7 -> lo=0x000E, hi=0x0002.
  - op=11, opa=0xFFF9 (-7), opb=0x0002 -> lo=0xFFFD, hi=0xFFFF.
  - op=11, opa=0x8000, opb=0xFFFF -> lo=0x8000, hi=0x0000.
- **Divide by zero:** op=10, opa=0x1234, opb=0 -> done on the cycle after accept, busy never high; hi=0x1234, lo=0xFFFF, dz=1. A following MULU 2*3 gives lo=0x0006, hi=0, dz=0.
- **Start while busy:** pulse start with new operands during CALC -> ignored; the original result is delivered on schedule. A start held high through the done cycle is accepted on that edge, and its result arrives 17 cycles later.
- **Mid-operation reset:** rst_n low during CALC -> immediately busy=0, done=0, hi=lo=0. After release, a fresh MULU 0x00FF*0x0101 -> hi=0x0000, lo=0xFFFF.
